// File: rtl/maquina_pkg.sv
// Shared definitions for the coffee machine: price/coin codes, payment states and colones decoding.
// Also consumed by the coffee FSM.
package maquina_pkg;

  localparam int W_COL = 12;

  localparam logic [3:0] PRECIO_500  = 4'b0001;
  localparam logic [3:0] PRECIO_1000 = 4'b0010;
  localparam logic [3:0] PRECIO_1500 = 4'b0011;
  localparam logic [3:0] PRECIO_750  = 4'b0100;
  localparam logic [3:0] PRECIO_1250 = 4'b0101;
  localparam logic [3:0] PRECIO_1750 = 4'b0110;
  localparam logic [3:0] PRECIO_2000 = 4'b0111;
  localparam logic [3:0] PRECIO_2250 = 4'b1000;

  localparam logic [1:0] MONEDA_100  = 2'b00;
  localparam logic [1:0] MONEDA_250  = 2'b01;
  localparam logic [1:0] MONEDA_500  = 2'b10;
  localparam logic [1:0] MONEDA_1000 = 2'b11;

  localparam logic [1:0] ESPERA      = 2'd0;
  localparam logic [1:0] ACUMULANDO  = 2'd1;
  localparam logic [1:0] COBRADO     = 2'd2;
  localparam logic [1:0] DEVOLVIENDO = 2'd3;

  // Unknown codes map to 0 colones; callers use precio_valido to tell them apart.
  function automatic logic [W_COL-1:0] precio_a_colones(input logic [3:0] code);
    logic [W_COL-1:0] res;
    case (code)
      PRECIO_500:  res = 12'd500;
      PRECIO_1000: res = 12'd1000;
      PRECIO_1500: res = 12'd1500;
      PRECIO_750:  res = 12'd750;
      PRECIO_1250: res = 12'd1250;
      PRECIO_1750: res = 12'd1750;
      PRECIO_2000: res = 12'd2000;
      PRECIO_2250: res = 12'd2250;
      default:     res = 12'd0;
    endcase
    return res;
  endfunction

  function automatic logic precio_valido(input logic [3:0] code);
    return (code >= PRECIO_500) && (code <= PRECIO_2250);
  endfunction

  function automatic logic [W_COL-1:0] moneda_a_colones(input logic [1:0] code);
    logic [W_COL-1:0] res;
    case (code)
      MONEDA_100:  res = 12'd100;
      MONEDA_250:  res = 12'd250;
      MONEDA_500:  res = 12'd500;
      MONEDA_1000: res = 12'd1000;
      default:     res = 12'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decodificador_precio.sv
// Combinational price decoder: 4-bit price code -> colones plus validity flag.
module decodificador_precio
  import maquina_pkg::*;
#(
  parameter int W_CRED = 12
) (
  input  logic [3:0]        precio,
  output logic [W_CRED-1:0] colones,
  output logic              valido
);

  assign colones = W_CRED'(precio_a_colones(precio));
  assign valido  = precio_valido(precio);

endmodule

// File: rtl/modulo_pago.sv
// Coin acceptor / payment stage ahead of the coffee FSM: accumulates credit, pays, refunds.
// Optional build macro PAGO_EXACTO_EN: reject any coin that would overpay the latched price.
module modulo_pago
  import maquina_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int W_CRED  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        precio,
  input  logic              moneda_valida,
  input  logic [1:0]        moneda,
  input  logic              cancelar,
  output logic              acepta_moneda,
  output logic [W_CRED-1:0] credito,
  output logic              PAGO_RECIBIDO,
  output logic [W_CRED-1:0] vuelto,
  output logic              vuelto_valido,
  output logic              devolucion,
  output logic              moneda_rechazada
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        est_r, est_n;
  logic [W_CRED-1:0] credito_r, cred_n, precio_lat_r, lat_n, vuelto_r, vuelto_n;
  logic [TW-1:0]     timer_r, tim_n;
  logic              acepta_r, pago_r, pago_n, vv_r, vv_n, dev_r, dev_n, rech_r, rech_n;

  logic [W_CRED-1:0] dec_colones_s, precio_s, cred_mas_s;
  logic              dec_valido_s, coin_s, exceso_s;

  decodificador_precio #(.W_CRED(W_CRED)) u_dec (
    .precio  (precio),
    .colones (dec_colones_s),
    .valido  (dec_valido_s)
  );

  // The live price only matters in ESPERA; afterwards the latched copy is authoritative.
  assign precio_s   = (est_r == ESPERA) ? dec_colones_s : precio_lat_r;
  assign coin_s     = moneda_valida & acepta_r;
  assign cred_mas_s = credito_r + W_CRED'(moneda_a_colones(moneda));
`ifdef PAGO_EXACTO_EN
  assign exceso_s   = (cred_mas_s > precio_s);
`else
  assign exceso_s   = 1'b0;
`endif

  // Next-state and next-output computation.
  always_comb begin
    est_n    = est_r;
    cred_n   = credito_r;
    lat_n    = precio_lat_r;
    tim_n    = timer_r;
    pago_n   = 1'b0;
    vv_n     = 1'b0;
    dev_n    = 1'b0;
    rech_n   = 1'b0;
    vuelto_n = {W_CRED{1'b0}};
    case (est_r)
      ESPERA: begin
        if (coin_s) begin
          if (!dec_valido_s || exceso_s) begin
            rech_n = 1'b1;
          end else begin
            lat_n  = dec_colones_s;
            cred_n = cred_mas_s;
            tim_n  = {TW{1'b0}};
            if (cred_mas_s >= dec_colones_s) begin
              est_n    = COBRADO;
              pago_n   = 1'b1;
              vv_n     = 1'b1;
              vuelto_n = cred_mas_s - dec_colones_s;
            end else begin
              est_n = ACUMULANDO;
            end
          end
        end else begin
          est_n = ESPERA;
        end
      end
      ACUMULANDO: begin
        if (coin_s) begin
          tim_n = {TW{1'b0}};
          if (exceso_s) begin
            rech_n = 1'b1;
          end else begin
            cred_n = cred_mas_s;
          end
        end else begin
          tim_n = timer_r + TW'(1);
        end
        // Cancel outranks a completing coin; that coin is still refunded.
        if (cancelar) begin
          est_n    = DEVOLVIENDO;
          dev_n    = 1'b1;
          vv_n     = 1'b1;
          vuelto_n = cred_n;
        end else if (coin_s && !exceso_s && (cred_mas_s >= precio_lat_r)) begin
          est_n    = COBRADO;
          pago_n   = 1'b1;
          vv_n     = 1'b1;
          vuelto_n = cred_mas_s - precio_lat_r;
        end else if (!coin_s && (timer_r == TW'(TIMEOUT - 1))) begin
          est_n    = DEVOLVIENDO;
          dev_n    = 1'b1;
          vv_n     = 1'b1;
          vuelto_n = credito_r;
        end else begin
          est_n = ACUMULANDO;
        end
      end
      COBRADO, DEVOLVIENDO: begin
        est_n  = ESPERA;
        cred_n = {W_CRED{1'b0}};
        lat_n  = {W_CRED{1'b0}};
        tim_n  = {TW{1'b0}};
      end
      default: begin
        est_n  = ESPERA;
        cred_n = {W_CRED{1'b0}};
        lat_n  = {W_CRED{1'b0}};
        tim_n  = {TW{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      est_r        <= ESPERA;
      credito_r    <= {W_CRED{1'b0}};
      precio_lat_r <= {W_CRED{1'b0}};
      timer_r      <= {TW{1'b0}};
      vuelto_r     <= {W_CRED{1'b0}};
      acepta_r     <= 1'b1;
      pago_r       <= 1'b0;
      vv_r         <= 1'b0;
      dev_r        <= 1'b0;
      rech_r       <= 1'b0;
    end else begin
      est_r        <= est_n;
      credito_r    <= cred_n;
      precio_lat_r <= lat_n;
      timer_r      <= tim_n;
      vuelto_r     <= vuelto_n;
      acepta_r     <= (est_n == ESPERA) || (est_n == ACUMULANDO);
      pago_r       <= pago_n;
      vv_r         <= vv_n;
      dev_r        <= dev_n;
      rech_r       <= rech_n;
    end
  end

  assign acepta_moneda    = acepta_r;
  assign credito          = credito_r;
  assign PAGO_RECIBIDO    = pago_r;
  assign vuelto           = vuelto_r;
  assign vuelto_valido    = vv_r;
  assign devolucion       = dev_r;
  assign moneda_rechazada = rech_r;

endmodule

// File: tb/tb_modulo_pago.sv
// Directed self-checking bench for modulo_pago (default TIMEOUT=8, W_CRED=12).
module tb_modulo_pago;

  logic        clk;
  logic        reset;
  logic [3:0]  precio;
  logic        moneda_valida;
  logic [1:0]  moneda;
  logic        cancelar;
  logic        acepta_moneda;
  logic [11:0] credito;
  logic        PAGO_RECIBIDO;
  logic [11:0] vuelto;
  logic        vuelto_valido;
  logic        devolucion;
  logic        moneda_rechazada;

  int total_s = 0;
  int bad_s   = 0;

  modulo_pago #(.TIMEOUT(8), .W_CRED(12)) dut (
    .clk              (clk),
    .reset            (reset),
    .precio           (precio),
    .moneda_valida    (moneda_valida),
    .moneda           (moneda),
    .cancelar         (cancelar),
    .acepta_moneda    (acepta_moneda),
    .credito          (credito),
    .PAGO_RECIBIDO    (PAGO_RECIBIDO),
    .vuelto           (vuelto),
    .vuelto_valido    (vuelto_valido),
    .devolucion       (devolucion),
    .moneda_rechazada (moneda_rechazada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total_s++;
    if (obs !== esp) begin
      bad_s++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] c);
    moneda_valida = 1'b1;
    moneda        = c;
    tick();
    moneda_valida = 1'b0;
  endtask

  initial begin
    reset = 1'b1; precio = 4'b0000; moneda_valida = 1'b0; moneda = 2'b00; cancelar = 1'b0;
    tick();
    tick();
    chequear("rst_acepta", 32'(acepta_moneda), 32'd1);
    chequear("rst_credito", 32'(credito), 32'd0);
    chequear("rst_pulsos", {28'd0, PAGO_RECIBIDO, vuelto_valido, devolucion, moneda_rechazada}, 32'd0);
    reset = 1'b0;
    tick();

    // Exact single-coin sale, then a coin offered during COBRADO is ignored
    precio = 4'b0001;
    moneda_valida = 1'b1; moneda = 2'b10;
    tick();
    chequear("a_pago", 32'(PAGO_RECIBIDO), 32'd1);
    chequear("a_vv", 32'(vuelto_valido), 32'd1);
    chequear("a_vuelto", 32'(vuelto), 32'd0);
    chequear("a_acepta", 32'(acepta_moneda), 32'd0);
    tick();
    moneda_valida = 1'b0;
    chequear("a_pago_off", 32'(PAGO_RECIBIDO), 32'd0);
    chequear("a_credito0", 32'(credito), 32'd0);
    chequear("a_ignorada", 32'(moneda_rechazada), 32'd0);
    chequear("a_acepta1", 32'(acepta_moneda), 32'd1);

`ifndef PAGO_EXACTO_EN
    // 750 price with 500+100+100+100 -> 50 change
    precio = 4'b0100;
    coin(2'b10); chequear("b_c1", 32'(credito), 32'd500);
    coin(2'b00); chequear("b_c2", 32'(credito), 32'd600);
    coin(2'b00); chequear("b_c3", 32'(credito), 32'd700);
    chequear("b_nopago", 32'(PAGO_RECIBIDO), 32'd0);
    coin(2'b00); chequear("b_c4", 32'(credito), 32'd800);
    chequear("b_pago", 32'(PAGO_RECIBIDO), 32'd1);
    chequear("b_vuelto", 32'(vuelto), 32'd50);
    tick();
    chequear("b_pulso1", 32'(PAGO_RECIBIDO), 32'd0);

    // Latched price: changing precio mid-transaction has no effect
    precio = 4'b0010;
    coin(2'b10);
    precio = 4'b0001;
    coin(2'b00);
    chequear("l_credito", 32'(credito), 32'd600);
    chequear("l_nopago", 32'(PAGO_RECIBIDO), 32'd0);
    coin(2'b11);
    chequear("l_pago", 32'(PAGO_RECIBIDO), 32'd1);
    chequear("l_vuelto", 32'(vuelto), 32'd600);
    tick();
`else
    // Exact-payment mode: overpaying coin rejected, timer reset, exact completion
    precio = 4'b0100;
    coin(2'b10); chequear("x_c1", 32'(credito), 32'd500);
    coin(2'b10);
    chequear("x_rech", 32'(moneda_rechazada), 32'd1);
    chequear("x_c2", 32'(credito), 32'd500);
    coin(2'b01);
    chequear("x_pago", 32'(PAGO_RECIBIDO), 32'd1);
    chequear("x_vuelto", 32'(vuelto), 32'd0);
    chequear("x_c3", 32'(credito), 32'd750);
    tick();
`endif

    // Inactivity timeout refunds the 1000 coin after 8 idle cycles
    precio = 4'b1000;
    coin(2'b11);
    chequear("t_credito", 32'(credito), 32'd1000);
    for (int i = 0; i < 7; i++) begin
      tick();
      chequear("t_espera", {30'd0, devolucion, PAGO_RECIBIDO}, 32'd0);
    end
    tick();
    chequear("t_dev", 32'(devolucion), 32'd1);
    chequear("t_vv", 32'(vuelto_valido), 32'd1);
    chequear("t_vuelto", 32'(vuelto), 32'd1000);
    chequear("t_nopago", 32'(PAGO_RECIBIDO), 32'd0);
    tick();
    chequear("t_credito0", 32'(credito), 32'd0);
    chequear("t_dev_off", 32'(devolucion), 32'd0);

    // Cancel with a coin in the same cycle: coin included in refund
    precio = 4'b0010;
    coin(2'b01);
    moneda_valida = 1'b1; moneda = 2'b01; cancelar = 1'b1;
    tick();
    moneda_valida = 1'b0; cancelar = 1'b0;
    chequear("c_dev", 32'(devolucion), 32'd1);
    chequear("c_vuelto", 32'(vuelto), 32'd500);
    chequear("c_nopago", 32'(PAGO_RECIBIDO), 32'd0);
    tick();
    chequear("c_credito0", 32'(credito), 32'd0);

    // Invalid price rejects the coin
    precio = 4'b0000;
    coin(2'b10);
    chequear("r_rech", 32'(moneda_rechazada), 32'd1);
    chequear("r_credito", 32'(credito), 32'd0);
    chequear("r_acepta", 32'(acepta_moneda), 32'd1);
    tick();
    chequear("r_rech_off", 32'(moneda_rechazada), 32'd0);

    // Reset mid-ACUMULANDO discards credit silently
    precio = 4'b0010;
    coin(2'b00);
    chequear("m_credito", 32'(credito), 32'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chequear("m_credito0", 32'(credito), 32'd0);
    chequear("m_vuelto0", 32'(vuelto), 32'd0);
    chequear("m_pulsos", {28'd0, PAGO_RECIBIDO, vuelto_valido, devolucion, moneda_rechazada}, 32'd0);
    chequear("m_acepta", 32'(acepta_moneda), 32'd1);

    $display("test done: total=%0d bad=%0d", total_s, bad_s);
    $finish;
  end

endmodule
